// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer states, x0 and the opcodes the decoder also uses.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  localparam logic [4:0] X0 = 5'd0;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] HALT   = 7'b1110101;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with a synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count on inc until every bit is set, then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage core: load-use stalls, redirect squashes and HALT drain.
module hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_Halt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_Redirect,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  seq_state_e state_q;
  logic [2:0] drain_cnt_q;
  logic       halted_q;
  logic       lu;
  logic       stall_inc;
  logic       flush_inc;

  // Rs fields are compared even for formats without them; a spurious bubble is harmless.
  assign lu = EX_MemRead && (EX_Rd != X0) && ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2));

  // Sequencer state: RUN until HALT is accepted, DRAIN for the older instructions, then HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      drain_cnt_q <= 3'd0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // A redirect squashes a wrong-path HALT; a load-use stall makes HALT wait a cycle.
          if (!EX_Redirect && !lu && ID_Halt) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 3'd0;
          end
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 3'd1;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  // Enables and flushes follow the current state and inputs in the same cycle.
  always_comb begin
    PCWrite   = 1'b0;
    IFIDWrite = 1'b0;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (reset) begin
      IFIDFlush = 1'b1;
    end else if (state_q == RUN) begin
      if (EX_Redirect) begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b1;
        flush_inc = 1'b1;
      end else if (lu) begin
        stall_inc = 1'b1;
      end else if (!ID_Halt) begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IDEXFlush = 1'b0;
      end
    end
  end

  assign Halted = halted_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .q     (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .q     (FlushCount)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a RUN-state vector table plus drain, reset and saturation runs.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic        halt, memread, redirect;
  logic        pcw, ifidw, ifidf, idexf, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_pcw, s_ifidw, s_ifidf, s_idexf, s_halted;
  logic [1:0]  s_stall, s_flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.DRAIN_CYCLES(3), .CNT_W(32)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .ID_Rs1      (rs1),
    .ID_Rs2      (rs2),
    .ID_Halt     (halt),
    .EX_MemRead  (memread),
    .EX_Rd       (rd),
    .EX_Redirect (redirect),
    .PCWrite     (pcw),
    .IFIDWrite   (ifidw),
    .IFIDFlush   (ifidf),
    .IDEXFlush   (idexf),
    .Halted      (halted),
    .StallCycles (stall_cnt),
    .FlushCount  (flush_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, to reach saturation quickly.
  hazard_sequencer #(.DRAIN_CYCLES(3), .CNT_W(2)) u_small (
    .clk         (clk),
    .reset       (reset),
    .ID_Rs1      (rs1),
    .ID_Rs2      (rs2),
    .ID_Halt     (halt),
    .EX_MemRead  (memread),
    .EX_Rd       (rd),
    .EX_Redirect (redirect),
    .PCWrite     (s_pcw),
    .IFIDWrite   (s_ifidw),
    .IFIDFlush   (s_ifidf),
    .IDEXFlush   (s_idexf),
    .Halted      (s_halted),
    .StallCycles (s_stall),
    .FlushCount  (s_flush)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       halt;
    logic       memread;
    logic       redirect;
    logic [3:0] exp_ctl;    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
    int         exp_stall;  // after the edge
    int         exp_flush;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic h, input logic m, input logic r);
    rs1 = a; rs2 = b; rd = d; halt = h; memread = m; redirect = r;
  endtask

  task automatic chk_ctl(input string name, input logic [3:0] exp);
    chk(name, {28'd0, pcw, ifidw, ifidf, idexf}, {28'd0, exp});
  endtask

  initial begin
    vecs[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 0, 0};  // idle
    vecs[1] = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 4'b0001, 1, 0};  // lu on rs2
    vecs[2] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1100, 1, 0};  // load to x0
    vecs[3] = '{5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 4'b0001, 2, 0};  // lu on rs1
    vecs[4] = '{5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 4'b1100, 2, 0};  // not a load
    vecs[5] = '{5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 4'b1111, 2, 1};  // redirect beats lu+halt
    vecs[6] = '{5'd0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 4'b0001, 3, 1};  // lu beats halt
    vecs[7] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b1111, 3, 2};  // plain redirect
    vecs[8] = '{5'd5, 5'd6, 5'd4, 1'b0, 1'b1, 1'b0, 4'b1100, 3, 2};  // load, no match

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 chk_ctl("ctl_in_reset", 4'b0011);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_flush", flush_cnt, 32'd0);

    // Table: each vector is one RUN-state cycle, starting and ending at a negedge.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].halt, vecs[i].memread,
            vecs[i].redirect);
      #1 chk_ctl($sformatf("vec%0d_ctl", i), vecs[i].exp_ctl);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].exp_stall);
      chk($sformatf("vec%0d_flush", i), flush_cnt, vecs[i].exp_flush);
      chk($sformatf("vec%0d_sstall", i), {30'd0, s_stall}, sat3(vecs[i].exp_stall));
      chk($sformatf("vec%0d_halted", i), {31'd0, halted}, 32'd0);
    end

    // Narrow counter is at 3; two more stalls must leave it pinned.
    for (int i = 0; i < 2; i++) begin
      drive(0, 5'd8, 5'd8, 0, 1, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_stall", i), stall_cnt, 32'd4 + i);
      chk($sformatf("sat%0d_sstall", i), {30'd0, s_stall}, 32'd3);
    end
    // Two redirects push the narrow flush counter from 2 to 3 and hold.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("sat%0d_sflush", i), {30'd0, s_flush}, 32'd3);
    end
    chk("sat_flush_main", flush_cnt, 32'd4);

    // HALT accepted, then three DRAIN cycles with redirect/lu noise, then HALTED.
    drive(0, 0, 0, 1, 0, 0);
    #1 chk_ctl("halt_ctl", 4'b0001);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #1 chk_ctl("drain0_ctl", 4'b0001);
    @(negedge clk);
    chk("drain1_halted", {31'd0, halted}, 32'd0);
    drive(5'd2, 0, 5'd2, 0, 1, 1);
    #1 chk_ctl("drain1_ctl", 4'b0001);
    @(negedge clk);
    chk("drain2_halted", {31'd0, halted}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("halted_rise", {31'd0, halted}, 32'd1);
    chk("drain_stall_hold", stall_cnt, 32'd5);
    chk("drain_flush_hold", flush_cnt, 32'd4);
    drive(0, 0, 0, 0, 0, 1);
    #1 chk_ctl("halted_ctl", 4'b0001);
    @(negedge clk);
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halted_flush_hold", flush_cnt, 32'd4);

    // Reset from HALTED.
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
    #1 chk_ctl("rst_run_ctl", 4'b1100);
    @(negedge clk);

    // Reset in the middle of DRAIN returns to RUN without halting.
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 chk_ctl("middrain_run_ctl", 4'b1100);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("middrain_no_halt", {31'd0, halted}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
